// File: rtl/fmc_dvi_cfg_pkg.sv
// Shared types and constants for the DVI/DP FMC power-up configuration sequencer.
package fmc_dvi_cfg_pkg;

    localparam int unsigned TBL_W   = 23;
    localparam int unsigned DEV_W   = 7;
    localparam int unsigned REG_W   = 8;
    localparam int unsigned DAT_W   = 8;
    localparam int unsigned CNT_W   = 8;

    // Field positions inside one table word {dev, reg, data}
    localparam int unsigned DEV_MSB = 22;
    localparam int unsigned DEV_LSB = 16;
    localparam int unsigned REG_MSB = 15;
    localparam int unsigned REG_LSB = 8;
    localparam int unsigned DAT_MSB = 7;
    localparam int unsigned DAT_LSB = 0;

    // Device address that terminates the table early
    localparam logic [DEV_W-1:0] END_MARK_DEF = 7'h7F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DELAY,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef struct packed {
        logic [DEV_W-1:0] dev;
        logic [REG_W-1:0] regaddr;
        logic [DAT_W-1:0] data;
    } tbl_entry_t;

    // Build one table word from its fields
    function automatic logic [TBL_W-1:0] tbl_pack(input logic [DEV_W-1:0] dev,
                                                  input logic [REG_W-1:0] regaddr,
                                                  input logic [DAT_W-1:0] data);
        logic [TBL_W-1:0] w;
        w                   = '0;
        w[DEV_MSB:DEV_LSB]  = dev;
        w[REG_MSB:REG_LSB]  = regaddr;
        w[DAT_MSB:DAT_LSB]  = data;
        return w;
    endfunction

endpackage

// File: rtl/fmc_dvi_cfg_rom.sv
// Init table for the DVI transmitter on the FMC card; unused slots hold the end mark.
module fmc_dvi_cfg_rom
    import fmc_dvi_cfg_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic [IDX_W-1:0] i_idx,
    output logic [TBL_W-1:0] o_tbl_data_c
);

    // Address-to-entry lookup
    always_comb begin
        o_tbl_data_c = tbl_pack(END_MARK_DEF, 8'h00, 8'h00);
        case (i_idx)
            IDX_W'(0): o_tbl_data_c = tbl_pack(7'h38, 8'h08, 8'h35);
            IDX_W'(1): o_tbl_data_c = tbl_pack(7'h38, 8'h09, 8'h38);
            IDX_W'(2): o_tbl_data_c = tbl_pack(7'h38, 8'h0A, 8'h80);
            IDX_W'(3): o_tbl_data_c = tbl_pack(7'h38, 8'h0C, 8'h89);
            IDX_W'(4): o_tbl_data_c = tbl_pack(7'h38, 8'h0E, 8'h10);
            default:   o_tbl_data_c = tbl_pack(END_MARK_DEF, 8'h00, 8'h00);
        endcase
    end

endmodule

// File: rtl/fmc_dvi_cfg_sequencer.sv
// Power-up configuration sequencer: waits a startup delay, then issues one I2C
// write per table entry with bounded NACK retry and early end-mark termination.
module fmc_dvi_cfg_sequencer
    import fmc_dvi_cfg_pkg::*;
#(
    parameter int unsigned      NUM_ENTRIES   = 16,
    parameter int unsigned      IDX_W         = 4,
    parameter int unsigned      STARTUP_DELAY = 1000,
    parameter int unsigned      MAX_RETRY     = 3,
    parameter logic [6:0]       END_MARK      = END_MARK_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [IDX_W-1:0] tbl_idx,
    input  logic [22:0]      tbl_data,
    output logic             i2c_req,
    output logic [6:0]       i2c_dev,
    output logic [7:0]       i2c_reg,
    output logic [7:0]       i2c_wdata,
    input  logic             i2c_ack,
    input  logic             i2c_nack,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [7:0]       count
);

    localparam int unsigned      DLY_W    = (STARTUP_DELAY > 1) ? $clog2(STARTUP_DELAY) : 1;
    localparam int unsigned      RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(STARTUP_DELAY - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    state_t           r_state, w_state_nxt;
    logic [DLY_W-1:0] r_dly, w_dly_nxt;
    logic [RTY_W-1:0] r_retry, w_retry_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_req, w_req_nxt;
    logic [6:0]       r_dev, w_dev_nxt;
    logic [7:0]       r_reg, w_reg_nxt;
    logic [7:0]       r_wdata, w_wdata_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_error, w_error_nxt;
    logic [7:0]       r_count, w_count_nxt;
    tbl_entry_t       w_entry;

    assign w_entry = tbl_entry_t'(tbl_data);

    // State register; reset drops straight into the startup delay
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_DELAY;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: if (start) w_state_nxt = ST_DELAY;
            ST_DELAY: if (r_dly == DLY_LAST) w_state_nxt = ST_FETCH;
            ST_FETCH: w_state_nxt = (w_entry.dev == END_MARK) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (i2c_ack) begin
                    if (!i2c_nack)              w_state_nxt = ST_NEXT;
                    else if (r_retry < RTY_MAX) w_state_nxt = ST_ISSUE;
                    else                        w_state_nxt = ST_ERROR;
                end
            end
            ST_NEXT: w_state_nxt = (r_idx == LAST_IDX) ? ST_DONE : ST_FETCH;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered datapath and status outputs
    always_comb begin
        w_dly_nxt   = r_dly;
        w_retry_nxt = r_retry;
        w_idx_nxt   = r_idx;
        w_dev_nxt   = r_dev;
        w_reg_nxt   = r_reg;
        w_wdata_nxt = r_wdata;
        w_count_nxt = r_count;
        // A retry passes through ISSUE with req low, giving the engine an idle cycle
        w_req_nxt   = (w_state_nxt == ST_WAIT) ||
                      ((w_state_nxt == ST_ISSUE) && (r_state == ST_FETCH));
        w_busy_nxt  = !(w_state_nxt inside {ST_IDLE, ST_DONE, ST_ERROR});
        w_done_nxt  = (w_state_nxt == ST_DONE);
        w_error_nxt = (w_state_nxt == ST_ERROR);
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    w_dly_nxt   = '0;
                    w_retry_nxt = '0;
                    w_idx_nxt   = '0;
                    w_count_nxt = '0;
                end
            end
            ST_DELAY: w_dly_nxt = (r_dly == DLY_LAST) ? '0 : r_dly + DLY_W'(1);
            ST_FETCH: begin
                w_dev_nxt   = w_entry.dev;
                w_reg_nxt   = w_entry.regaddr;
                w_wdata_nxt = w_entry.data;
            end
            ST_WAIT: begin
                if (i2c_ack) begin
                    if (!i2c_nack) begin
                        w_count_nxt = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
                        w_retry_nxt = '0;
                    end else if (r_retry < RTY_MAX) begin
                        w_retry_nxt = r_retry + RTY_W'(1);
                    end
                end
            end
            ST_NEXT: if (r_idx != LAST_IDX) w_idx_nxt = r_idx + IDX_W'(1);
            default: ;
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dly   <= '0;
            r_retry <= '0;
            r_idx   <= '0;
            r_req   <= 1'b0;
            r_dev   <= '0;
            r_reg   <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_count <= '0;
        end else begin
            r_dly   <= w_dly_nxt;
            r_retry <= w_retry_nxt;
            r_idx   <= w_idx_nxt;
            r_req   <= w_req_nxt;
            r_dev   <= w_dev_nxt;
            r_reg   <= w_reg_nxt;
            r_wdata <= w_wdata_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_error <= w_error_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign tbl_idx   = r_idx;
    assign i2c_req   = r_req;
    assign i2c_dev   = r_dev;
    assign i2c_reg   = r_reg;
    assign i2c_wdata = r_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign count     = r_count;

endmodule
